// File: rtl/vdp_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vdp_port_ctrl
// Brief    : CPU-side port controller for a TMS9918-style video processor.
//            Holds R0-R7, the VRAM address pointer, the read-ahead buffer and
//            the sticky status flags. Sequences CPU VRAM reads and writes.
// Revision : 1.0 - initial release
// ============================================================================
module vdp_port_ctrl #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              port_sel,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              busy,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_wr,
  output logic              vram_rd,
  output logic [7:0]        vram_wdata,
  input  logic [7:0]        vram_rdata,
  output logic [2:0]        mode,
  output logic              video_on,
  output logic              sprite_large,
  output logic              sprite_enlarged,
  output logic [ADDR_W-1:0] name_table_addr,
  output logic [ADDR_W-1:0] color_table_addr,
  output logic [ADDR_W-1:0] font_addr,
  output logic [ADDR_W-1:0] sprite_attr_addr,
  output logic [ADDR_W-1:0] sprite_pattern_table_addr,
  output logic [3:0]        text_color,
  output logic [3:0]        back_color,
  input  logic              frame_int,
  input  logic              collision_in,
  input  logic              fifth_in,
  input  logic [4:0]        sprite5_in,
  output logic              n_int
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_REQ  = 2'd1,
    ST_RD_WAIT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0][7:0] regs_q, regs_d;
  logic [13:0]     ptr_q, ptr_d;
  logic [7:0]      buf_q, buf_d;
  logic [7:0]      latch_q, latch_d;
  logic            latch_full_q, latch_full_d;
  logic            write_mode_q, write_mode_d;
  logic            f_q, f_d, c_q, c_d, s5_q, s5_d;
  logic [4:0]      sprite5_q, sprite5_d;
  logic [7:0]      dout_q, dout_d;
  logic            vram_wr_q, vram_wr_d;
  logic [7:0]      wdata_q, wdata_d;

  logic data_wr, data_rd, ctrl_wr, stat_rd;
  logic unused_bits;

  // Strobe decode: a simultaneous write and read is treated as a write only.
  assign data_wr = cpu_wr & ~port_sel;
  assign data_rd = cpu_rd & ~cpu_wr & ~port_sel;
  assign ctrl_wr = cpu_wr & port_sel;
  assign stat_rd = cpu_rd & ~cpu_wr & port_sel;

  // The pointer advances at the end of the write cycle, so vram_addr is
  // always the live pointer for both reads and writes.
  assign busy       = (state_q != ST_IDLE) | vram_wr_q;
  assign vram_wr    = vram_wr_q;
  assign vram_rd    = (state_q == ST_RD_REQ);
  assign vram_addr  = ADDR_W'(ptr_q);
  assign vram_wdata = wdata_q;
  assign cpu_dout   = dout_q;

  // Register-file decode; M1 beats M3 beats M2, default is graphics I.
  assign mode = regs_q[1][4] ? 3'd0 :
                regs_q[0][1] ? 3'd2 :
                regs_q[1][3] ? 3'd3 : 3'd1;
  assign video_on                  = regs_q[1][6];
  assign sprite_large              = regs_q[1][1];
  assign sprite_enlarged           = regs_q[1][0];
  assign name_table_addr           = ADDR_W'({regs_q[2][3:0], 10'b0});
  assign color_table_addr          = ADDR_W'({regs_q[3], 6'b0});
  assign font_addr                 = ADDR_W'({regs_q[4][2:0], 11'b0});
  assign sprite_attr_addr          = ADDR_W'({regs_q[5][6:0], 7'b0});
  assign sprite_pattern_table_addr = ADDR_W'({regs_q[6][2:0], 11'b0});
  assign text_color                = regs_q[7][7:4];
  assign back_color                = regs_q[7][3:0];
  assign n_int                     = ~(f_q & regs_q[1][5]);

  // Register bits with no decoded function, plus the stored write_mode flag.
  assign unused_bits = ^{write_mode_q, regs_q[0][7:2], regs_q[0][0],
                         regs_q[1][7], regs_q[1][2], regs_q[2][7:4],
                         regs_q[4][7:3], regs_q[5][7], regs_q[6][7:3]};

  // Next-state logic: FSM, CPU port handling and status flag updates.
  always_comb begin
    state_d      = state_q;
    regs_d       = regs_q;
    ptr_d        = ptr_q;
    buf_d        = buf_q;
    latch_d      = latch_q;
    latch_full_d = latch_full_q;
    write_mode_d = write_mode_q;
    f_d          = f_q;
    c_d          = c_q;
    s5_d         = s5_q;
    sprite5_d    = sprite5_q;
    dout_d       = dout_q;
    vram_wr_d    = 1'b0;
    wdata_d      = wdata_q;

    // Prefetch sequencing; the 14-bit pointer wraps naturally.
    case (state_q)
      ST_RD_REQ:  state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        buf_d   = vram_rdata;
        ptr_d   = ptr_q + 14'd1;
        state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase

    if (vram_wr_q) ptr_d = ptr_q + 14'd1;

    // Data port: any strobe breaks a half-written control pair.
    if (data_wr | data_rd) latch_full_d = 1'b0;
    if (!busy) begin
      if (data_wr) begin
        vram_wr_d = 1'b1;
        wdata_d   = cpu_din;
        buf_d     = cpu_din;
      end else if (data_rd) begin
        dout_d  = buf_q;
        state_d = ST_RD_REQ;
      end
    end

    // Control port is always accepted; a pointer load overrides any
    // increment and restarts the read-ahead in read mode.
    if (ctrl_wr) begin
      if (!latch_full_q) begin
        latch_d      = cpu_din;
        latch_full_d = 1'b1;
      end else begin
        latch_full_d = 1'b0;
        case (cpu_din[7:6])
          2'b10: regs_d[cpu_din[2:0]] = latch_q;
          2'b01: begin
            ptr_d        = {cpu_din[5:0], latch_q};
            write_mode_d = 1'b1;
          end
          2'b00: begin
            ptr_d        = {cpu_din[5:0], latch_q};
            write_mode_d = 1'b0;
            state_d      = ST_RD_REQ;
          end
          default: ;
        endcase
      end
    end

    if (stat_rd) begin
      dout_d       = {f_q, s5_q, c_q, sprite5_q};
      latch_full_d = 1'b0;
      f_d          = 1'b0;
      c_d          = 1'b0;
      s5_d         = 1'b0;
    end

    // Flag sets come last so they win over a same-cycle status read.
    if (frame_int)    f_d = 1'b1;
    if (collision_in) c_d = 1'b1;
    if (fifth_in && !s5_q) begin
      s5_d      = 1'b1;
      sprite5_d = sprite5_in;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= ST_IDLE;
      regs_q       <= '0;
      ptr_q        <= '0;
      buf_q        <= '0;
      latch_q      <= '0;
      latch_full_q <= 1'b0;
      write_mode_q <= 1'b0;
      f_q          <= 1'b0;
      c_q          <= 1'b0;
      s5_q         <= 1'b0;
      sprite5_q    <= '0;
      dout_q       <= '0;
      vram_wr_q    <= 1'b0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      regs_q       <= regs_d;
      ptr_q        <= ptr_d;
      buf_q        <= buf_d;
      latch_q      <= latch_d;
      latch_full_q <= latch_full_d;
      write_mode_q <= write_mode_d;
      f_q          <= f_d;
      c_q          <= c_d;
      s5_q         <= s5_d;
      sprite5_q    <= sprite5_d;
      dout_q       <= dout_d;
      vram_wr_q    <= vram_wr_d;
      wdata_q      <= wdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vdp_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vdp_port_ctrl
// Brief    : Self-checking bench for vdp_port_ctrl with a behavioural VRAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vdp_port_ctrl;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        port_sel, cpu_wr, cpu_rd;
  logic [7:0]  cpu_din, cpu_dout;
  logic        busy;
  logic [13:0] vram_addr;
  logic        vram_wr, vram_rd;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata = 8'h00;
  logic [2:0]  mode;
  logic        video_on, sprite_large, sprite_enlarged;
  logic [13:0] name_table_addr, color_table_addr, font_addr;
  logic [13:0] sprite_attr_addr, sprite_pattern_table_addr;
  logic [3:0]  text_color, back_color;
  logic        frame_int, collision_in, fifth_in;
  logic [4:0]  sprite5_in;
  logic        n_int;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:16383];

  vdp_port_ctrl #(.ADDR_W(14)) dut (
    .clk(clk), .n_reset(n_reset), .port_sel(port_sel), .cpu_wr(cpu_wr),
    .cpu_rd(cpu_rd), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .busy(busy),
    .vram_addr(vram_addr), .vram_wr(vram_wr), .vram_rd(vram_rd),
    .vram_wdata(vram_wdata), .vram_rdata(vram_rdata), .mode(mode),
    .video_on(video_on), .sprite_large(sprite_large),
    .sprite_enlarged(sprite_enlarged), .name_table_addr(name_table_addr),
    .color_table_addr(color_table_addr), .font_addr(font_addr),
    .sprite_attr_addr(sprite_attr_addr),
    .sprite_pattern_table_addr(sprite_pattern_table_addr),
    .text_color(text_color), .back_color(back_color), .frame_int(frame_int),
    .collision_in(collision_in), .fifth_in(fifth_in),
    .sprite5_in(sprite5_in), .n_int(n_int)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_init(input int a);
    return 8'((a * 7) + 3 + (a >> 8));
  endfunction

  // VRAM model: read data appears one cycle after vram_rd.
  always @(posedge clk) begin
    if (vram_rd) vram_rdata <= mem[vram_addr];
    if (vram_wr) mem[vram_addr] <= vram_wdata;
  end

  function automatic logic [83:0] dec_act();
    return {mode, video_on, sprite_large, sprite_enlarged, name_table_addr,
            color_table_addr, font_addr, sprite_attr_addr,
            sprite_pattern_table_addr, text_color, back_color};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ctrl_write(input logic [7:0] b);
    port_sel = 1'b1; cpu_wr = 1'b1; cpu_din = b;
    cyc();
    cpu_wr = 1'b0;
  endtask

  task automatic data_write(input logic [7:0] b, input logic with_rd);
    port_sel = 1'b0; cpu_wr = 1'b1; cpu_rd = with_rd; cpu_din = b;
    cyc();
    cpu_wr = 1'b0; cpu_rd = 1'b0;
  endtask

  task automatic data_read();
    port_sel = 1'b0; cpu_rd = 1'b1;
    cyc();
    cpu_rd = 1'b0;
  endtask

  task automatic stat_read();
    port_sel = 1'b1; cpu_rd = 1'b1;
    cyc();
    cpu_rd = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  ri;
    logic [7:0]  val;
    logic [2:0]  e_mode;
    logic        e_vid, e_sl, e_se;
    logic [13:0] e_name, e_col, e_font, e_satt, e_spat;
    logic [3:0]  e_tc, e_bc;
  } vec_t;

  vec_t vt [12];

  initial begin
    // Cumulative register writes from reset, with the full decoded state.
    vt[0]  = '{3'd1, 8'h40, 3'd1, 1'b1, 1'b0, 1'b0, 14'h0,    14'h0,    14'h0,    14'h0,    14'h0,    4'h0, 4'h0};
    vt[1]  = '{3'd1, 8'h52, 3'd0, 1'b1, 1'b1, 1'b0, 14'h0,    14'h0,    14'h0,    14'h0,    14'h0,    4'h0, 4'h0};
    vt[2]  = '{3'd0, 8'h02, 3'd0, 1'b1, 1'b1, 1'b0, 14'h0,    14'h0,    14'h0,    14'h0,    14'h0,    4'h0, 4'h0};
    vt[3]  = '{3'd1, 8'h09, 3'd2, 1'b0, 1'b0, 1'b1, 14'h0,    14'h0,    14'h0,    14'h0,    14'h0,    4'h0, 4'h0};
    vt[4]  = '{3'd0, 8'h00, 3'd3, 1'b0, 1'b0, 1'b1, 14'h0,    14'h0,    14'h0,    14'h0,    14'h0,    4'h0, 4'h0};
    vt[5]  = '{3'd1, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0, 14'h0,    14'h0,    14'h0,    14'h0,    14'h0,    4'h0, 4'h0};
    vt[6]  = '{3'd2, 8'hFF, 3'd1, 1'b0, 1'b0, 1'b0, 14'h3C00, 14'h0,    14'h0,    14'h0,    14'h0,    4'h0, 4'h0};
    vt[7]  = '{3'd3, 8'hA5, 3'd1, 1'b0, 1'b0, 1'b0, 14'h3C00, 14'h2940, 14'h0,    14'h0,    14'h0,    4'h0, 4'h0};
    vt[8]  = '{3'd4, 8'hFF, 3'd1, 1'b0, 1'b0, 1'b0, 14'h3C00, 14'h2940, 14'h3800, 14'h0,    14'h0,    4'h0, 4'h0};
    vt[9]  = '{3'd5, 8'hFF, 3'd1, 1'b0, 1'b0, 1'b0, 14'h3C00, 14'h2940, 14'h3800, 14'h3F80, 14'h0,    4'h0, 4'h0};
    vt[10] = '{3'd6, 8'h05, 3'd1, 1'b0, 1'b0, 1'b0, 14'h3C00, 14'h2940, 14'h3800, 14'h3F80, 14'h2800, 4'h0, 4'h0};
    vt[11] = '{3'd7, 8'h4C, 3'd1, 1'b0, 1'b0, 1'b0, 14'h3C00, 14'h2940, 14'h3800, 14'h3F80, 14'h2800, 4'h4, 4'hC};

    for (int i = 0; i < 16384; i++) mem[i] = mem_init(i);

    n_reset = 1'b0; port_sel = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0;
    cpu_din = 8'h00; frame_int = 1'b0; collision_in = 1'b0;
    fifth_in = 1'b0; sprite5_in = 5'h00;
    cyc(); cyc();
    chk("reset_outputs", {cpu_dout, vram_wr, vram_rd, busy, n_int, mode, video_on},
        {8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0});
    n_reset = 1'b1;
    cyc();

    // Register write / decode table.
    for (int i = 0; i < 12; i++) begin
      ctrl_write(vt[i].val);
      ctrl_write({5'b10000, vt[i].ri});
      chk($sformatf("decode_vec%0d", i), dec_act(),
          {vt[i].e_mode, vt[i].e_vid, vt[i].e_sl, vt[i].e_se, vt[i].e_name,
           vt[i].e_col, vt[i].e_font, vt[i].e_satt, vt[i].e_spat,
           vt[i].e_tc, vt[i].e_bc});
    end

    // Write mode at 0x3F00, consecutive data writes.
    ctrl_write(8'h00); ctrl_write(8'h7F);
    data_write(8'hAA, 1'b0);
    chk("wr_aa", {vram_wr, busy, vram_addr, vram_wdata}, {1'b1, 1'b1, 14'h3F00, 8'hAA});
    cyc();
    data_write(8'hBB, 1'b0);
    chk("wr_bb", {vram_wr, busy, vram_addr, vram_wdata}, {1'b1, 1'b1, 14'h3F01, 8'hBB});
    cyc();
    data_write(8'hCC, 1'b0);
    chk("wr_cc_ptr", {vram_wr, vram_addr, vram_wdata}, {1'b1, 14'h3F02, 8'hCC});
    data_write(8'hDD, 1'b0);
    chk("wr_while_busy_ignored", {vram_wr, busy}, {1'b0, 1'b0});
    data_write(8'hEE, 1'b1);
    chk("wr_and_rd_is_write", {vram_wr, vram_addr, vram_wdata}, {1'b1, 14'h3F03, 8'hEE});
    cyc();
    chk("wr_and_rd_no_read", {vram_rd, busy}, {1'b0, 1'b0});

    // Read back what was written.
    ctrl_write(8'h00); ctrl_write(8'h3F);
    cyc(); cyc();
    data_read();
    chk("readback_aa", cpu_dout, 8'hAA);
    cyc(); cyc();
    data_read();
    chk("readback_bb", cpu_dout, 8'hBB);
    cyc(); cyc();

    // Prefetch at 0x3FFF and pointer wrap.
    ctrl_write(8'hFF); ctrl_write(8'h3F);
    chk("prefetch_req", {vram_rd, busy, vram_addr}, {1'b1, 1'b1, 14'h3FFF});
    cyc();
    chk("prefetch_wait", {vram_rd, busy}, {1'b0, 1'b1});
    cyc();
    chk("prefetch_done", busy, 1'b0);
    data_read();
    chk("read_3fff", {cpu_dout, vram_rd, vram_addr}, {mem_init(16383), 1'b1, 14'h0000});
    cyc(); cyc();
    data_read();
    chk("read_wrapped_0000", cpu_dout, mem_init(0));
    cyc(); cyc();

    // Status read breaks a half-written control pair.
    ctrl_write(8'h12);
    stat_read();
    ctrl_write(8'h87);
    chk("no_reg_change", {text_color, back_color}, {4'h4, 4'hC});
    ctrl_write(8'h81);
    chk("87_latched", {video_on, sprite_large, sprite_enlarged, mode}, {1'b0, 1'b1, 1'b1, 3'd1});

    // Frame interrupt.
    ctrl_write(8'h20); ctrl_write(8'h81);
    frame_int = 1'b1; cyc(); frame_int = 1'b0;
    chk("n_int_low", n_int, 1'b0);
    stat_read();
    chk("status_frame", cpu_dout, 8'h80);
    chk("n_int_cleared", n_int, 1'b1);

    // Collision and fifth-sprite flags, capture once, set beats clear.
    fifth_in = 1'b1; sprite5_in = 5'h15; collision_in = 1'b1;
    cyc();
    sprite5_in = 5'h0A; collision_in = 1'b0;
    cyc();
    fifth_in = 1'b0; collision_in = 1'b1;
    stat_read();
    collision_in = 1'b0;
    chk("status_s5_c", cpu_dout, 8'h75);
    stat_read();
    chk("status_set_priority", cpu_dout, 8'h35);

    // Reset during RD_WAIT.
    ctrl_write(8'h00); ctrl_write(8'h00);
    cyc();
    chk("in_rd_wait", {busy, vram_rd}, {1'b1, 1'b0});
    n_reset = 1'b0;
    #1;
    chk("reset_midread_busy", {busy, vram_rd, vram_wr, n_int}, {1'b0, 1'b0, 1'b0, 1'b1});
    chk("reset_regs_zero", dec_act(), {3'd1, 81'h0});
    cyc(); cyc();
    n_reset = 1'b1;
    cyc();
    data_read();
    chk("reset_buffer_zero", cpu_dout, 8'h00);
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
